// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller: the frame FSM encoding,
// the legal oversampling ratios and the default word width.
package uart_rx_pkg;

  localparam int DATA_WIDTH = 8;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Map any unsupported oversampling ratio onto 8 so a bad setting still
  // produces a well-defined bit period.
  function automatic logic [5:0] legal_prescale(input logic [5:0] i_ps);
    case (i_ps)
      PRESCALE_8, PRESCALE_16, PRESCALE_32: return i_ps;
      default:                              return PRESCALE_8;
    endcase
  endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// Oversample edge counter and data-bit counter for the UART receiver.
// Both counters rest at zero while disabled, so every frame starts from a
// clean edge index without an explicit clear.
module edge_bit_counter #(
  parameter int   DATA_WIDTH = uart_rx_pkg::DATA_WIDTH,
  localparam int  BIT_CNT_W  = $clog2(DATA_WIDTH + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  input  logic                 i_bit_inc,
  input  logic [5:0]           i_prescale,
  output logic [5:0]           o_edge_cnt,
  output logic [BIT_CNT_W-1:0] o_bit_cnt,
  output logic                 o_bit_end
);

  logic [5:0]           r_edge_cnt;
  logic [BIT_CNT_W-1:0] r_bit_cnt;

  assign o_bit_end  = i_enable && (r_edge_cnt == (i_prescale - 6'd1));
  assign o_edge_cnt = r_edge_cnt;
  assign o_bit_cnt  = r_bit_cnt;

  // Edge index wraps at the end of each bit; bit count advances on request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_edge_cnt <= 6'd0;
      r_bit_cnt  <= '0;
    end else if (!i_enable) begin
      r_edge_cnt <= 6'd0;
      r_bit_cnt  <= '0;
    end else begin
      r_edge_cnt <= o_bit_end ? 6'd0 : r_edge_cnt + 6'd1;
      if (i_bit_inc) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM, LSB-first shift register, parity and
// stop checks, and the registered word/flag outputs. Bit timing comes from
// edge_bit_counter; sampling itself is done by an external majority voter.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = uart_rx_pkg::DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_bit,
  output logic                  samp_en,
  output logic [5:0]            edge_cnt,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  import uart_rx_pkg::*;

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic                  r_data_valid;
  logic                  r_par_err;
  logic                  r_stp_err;
  logic [5:0]            r_prescale;
  logic                  r_par_en;
  logic                  r_par_typ;

  logic                  w_active;
  logic                  w_bit_end;
  logic                  w_bit_inc;
  logic                  w_par_exp;
  logic [BIT_CNT_W-1:0]  w_bit_cnt;
  logic [5:0]            w_edge_cnt;

  assign w_active  = (r_state != ST_IDLE);
  assign w_bit_inc = (r_state == ST_DATA) && w_bit_end;
  // Even parity expects the XOR of the word, odd parity its complement.
  assign w_par_exp = r_par_typ ? ~(^r_shift) : (^r_shift);

  edge_bit_counter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_edge_bit_counter (
    .i_clk      (CLK),
    .i_rst_n    (RST),
    .i_enable   (w_active),
    .i_bit_inc  (w_bit_inc),
    .i_prescale (r_prescale),
    .o_edge_cnt (w_edge_cnt),
    .o_bit_cnt  (w_bit_cnt),
    .o_bit_end  (w_bit_end)
  );

  assign samp_en    = w_active;
  assign busy       = w_active;
  assign edge_cnt   = w_edge_cnt;
  assign P_DATA     = r_p_data;
  assign data_valid = r_data_valid;
  assign par_err    = r_par_err;
  assign stp_err    = r_stp_err;

  // Frame FSM with all datapath and output registers; acts only at bit ends.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_p_data     <= '0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
      r_prescale   <= PRESCALE_8;
      r_par_en     <= 1'b0;
      r_par_typ    <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!RX_IN) begin
            r_state    <= ST_START;
            r_prescale <= legal_prescale(prescale);
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
            r_par_err  <= 1'b0;
            r_stp_err  <= 1'b0;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            // A high sample means the falling edge was only a glitch.
            r_state <= sampled_bit ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_shift <= {sampled_bit, r_shift[DATA_WIDTH-1:1]};
            if (w_bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1)) begin
              r_state <= r_par_en ? ST_PARITY : ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            r_par_err <= (sampled_bit != w_par_exp);
            r_state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            r_stp_err <= ~sampled_bit;
            r_state   <= ST_IDLE;
            if (!r_par_err && sampled_bit) begin
              r_p_data     <= r_shift;
              r_data_valid <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of data bits per frame, LSB first.
REQ-002 CLK  input  1  receiver oversampling clock; all state updates on its rising edge.
REQ-003 RST  input  1  reset, asynchronous and active-low.
REQ-004 RX_IN  input  1  serial line; idle level is 1.
REQ-005 prescale  input  6  oversampling ratio; legal values 8, 16 and 32.
REQ-006 PAR_EN  input  1  1 = a parity bit follows the data bits.
REQ-007 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 sampled_bit  input  1  majority-voted bit from the external sampler; valid when edge_cnt == prescale-1.
REQ-009 samp_en  output  1  enables the sampler; high in every state except IDLE.
REQ-010 edge_cnt  output  6  oversample edge index within the current bit.
REQ-011 P_DATA  output  DATA_WIDTH  last error-free received word.
REQ-012 data_valid  output  1  one-cycle pulse when P_DATA is updated.
REQ-013 par_err, stp_err  output  1 each  error flags for the last frame.
REQ-014 busy  output  1  high while a frame is in progress.

Function
REQ-015 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP, held in a registered state vector.
REQ-016 IDLE: when RX_IN == 0, go to START with edge_cnt = 0 and bit_cnt = 0; latch prescale, PAR_EN and PAR_TYP at that moment.
REQ-017 Latched configuration SHALL be used for the whole frame; input changes mid-frame are ignored.
REQ-018 An illegal latched prescale value SHALL behave as 8.
REQ-019 In non-IDLE states, edge_cnt SHALL increment every cycle and wrap from prescale-1 to 0; a bit ends at the cycle where edge_cnt == prescale-1.
REQ-020 START, at bit end: if sampled_bit == 0, go to DATA; otherwise return to IDLE (glitch) with no flags raised and no data_valid.
REQ-021 DATA, at each bit end: shift sampled_bit in (right shift, new bit at MSB) and increment bit_cnt.
REQ-022 DATA exit: after DATA_WIDTH bits, go to PARITY if PAR_EN == 1, else go to STOP.
REQ-023 PARITY, at bit end: par_err <= (sampled_bit != expected), where expected = XOR of the data for even parity and XNOR of the data for odd parity; then go to STOP.
REQ-024 STOP, at bit end: stp_err <= (sampled_bit == 0); go to IDLE.
REQ-025 On STOP exit with both flags 0: P_DATA <= shift register and data_valid = 1 in the following cycle only.
REQ-026 On STOP exit with either flag set: P_DATA SHALL be held and data_valid SHALL stay 0.
REQ-027 par_err and stp_err SHALL hold their values until the next IDLE->START transition, which clears both.
REQ-028 busy SHALL equal (state != IDLE).
REQ-029 A falling RX_IN one cycle after STOP exit SHALL start the next frame normally (back-to-back frames).
REQ-030 Frame length SHALL be (1 + DATA_WIDTH + PAR_EN + 1) × prescale cycles from START entry to STOP exit.

Reset
REQ-031 While RST is low: state = IDLE, edge_cnt = 0, bit_cnt = 0, shift register = 0, P_DATA = 0, data_valid = 0, par_err = 0, stp_err = 0, samp_en = 0, busy = 0, latched configuration = prescale 8 with parity disabled.
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately with no data_valid; the first frame after release SHALL be received correctly.

Structure
REQ-033 The state encoding, the legal prescale constants and DATA_WIDTH SHALL live in a shared uart_rx_pkg package.
REQ-034 The edge and bit counting SHALL be a sub-module, edge_bit_counter (inputs: enable, prescale, DATA_WIDTH; outputs: edge_cnt, bit_cnt, bit_end); the FSM, shift register, parity check and output registers stay in uart_rx_ctrl.

Verification
REQ-035 prescale=8, PAR_EN=0, frame 0xA5 with stop bit 1: data_valid pulses once, 81 cycles after the first cycle of RX_IN low, with P_DATA=0xA5, par_err=0 and stp_err=0.
REQ-036 prescale=16, PAR_EN=1, PAR_TYP=0, frame 0x3C with parity bit 0: data_valid=1, P_DATA=0x3C. Same frame with parity bit 1: par_err=1, no data_valid, P_DATA unchanged.
REQ-037 prescale=8, RX_IN low for only 3 cycles with sampled_bit=1 at edge 7: FSM back in IDLE after 8 cycles, no flags, no data_valid.
REQ-038 prescale=32, frame 0x55 with stop bit 0: stp_err=1, no data_valid; the next good frame 0x0F clears stp_err and gives P_DATA=0x0F.
REQ-039 prescale=16, RST pulsed low during DATA bit 4: all outputs read 0 within the same cycle; the next frame 0xFF is received correctly.
REQ-040 prescale=8, frames 0x00 and 0xFF back-to-back with no idle gap: two data_valid pulses with the correct values.
